// File: rtl/bnn_loader_if.sv
// Host byte stream, controller SRAM buses and SRAM-side outputs of the BNN loader.
// The loader sits on the slave modport; the host/SRAM environment on the master.
interface bnn_loader_if #(
  parameter int INST_AW = 11,
  parameter int DATA_AW = 13
);
  logic               host_valid;
  logic [7:0]         host_data;
  logic               host_ready;
  logic [INST_AW+1:0] ctrl_instsram;
  logic [DATA_AW+1:0] ctrl_datasram;
  logic [15:0]        core_wdata;
  logic [INST_AW+1:0] instsram_ctrl;
  logic [15:0]        instsram_wdata;
  logic [DATA_AW+1:0] datasram_ctrl;
  logic [15:0]        datasram_wdata;
  logic               ctrl_rst;
  logic               ctrl_pause;
  logic               load_err;

  modport master (
    output host_valid, host_data, ctrl_instsram, ctrl_datasram, core_wdata,
    input  host_ready, instsram_ctrl, instsram_wdata, datasram_ctrl, datasram_wdata,
           ctrl_rst, ctrl_pause, load_err
  );

  modport slave (
    input  host_valid, host_data, ctrl_instsram, ctrl_datasram, core_wdata,
    output host_ready, instsram_ctrl, instsram_wdata, datasram_ctrl, datasram_wdata,
           ctrl_rst, ctrl_pause, load_err
  );
endinterface

// File: rtl/bnn_loader.sv
// Host-side loader: writes 16-bit words from a byte stream into instruction/data SRAM,
// then hands both SRAM buses to the BNN controller on RUN and releases its reset.
module bnn_loader #(
  parameter int INST_AW = 11,
  parameter int DATA_AW = 13
) (
  input  logic         clk,
  input  logic         rst,
  bnn_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_CNT_H, S_CNT_L, S_DATA_H, S_DATA_L, S_RUN
  } state_t;

  localparam logic [7:0] CMD_PAUSE = 8'hA0;
  localparam logic [7:0] CMD_INST  = 8'hA1;
  localparam logic [7:0] CMD_DATA  = 8'hA2;
  localparam logic [7:0] CMD_STOP  = 8'hA3;
  localparam logic [7:0] CMD_RUN   = 8'hA5;
  localparam logic [DATA_AW-1:0] ADDR_ONE = 1;

  state_t             state, state_nx;
  logic               ready_q;
  logic               accept;
  logic               run_mode;
  logic               tgt_data_q;
  logic [DATA_AW-1:0] addr_q;
  logic [15:0]        cnt_q;
  logic [7:0]         hi_q;
  logic               pause_q;
  logic               err_q;

  logic               inst_cen_q, inst_wen_q;
  logic [INST_AW-1:0] inst_addr_q;
  logic [15:0]        inst_wdata_q;
  logic               data_cen_q, data_wen_q;
  logic [DATA_AW-1:0] data_addr_q;
  logic [15:0]        data_wdata_q;

  assign accept   = bus.host_valid && ready_q;
  assign run_mode = (state == S_RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    if (accept) begin
      case (state)
        S_IDLE: begin
          if (bus.host_data == CMD_INST || bus.host_data == CMD_DATA) state_nx = S_ADDR_H;
          else if (bus.host_data == CMD_RUN)                          state_nx = S_RUN;
        end
        S_ADDR_H: state_nx = S_ADDR_L;
        S_ADDR_L: state_nx = S_CNT_H;
        S_CNT_H:  state_nx = S_CNT_L;
        S_CNT_L:  state_nx = ({cnt_q[15:8], bus.host_data} == 16'd0) ? S_IDLE : S_DATA_H;
        S_DATA_H: state_nx = S_DATA_L;
        S_DATA_L: state_nx = (cnt_q == 16'd1) ? S_IDLE : S_DATA_H;
        S_RUN: begin
          if (bus.host_data == CMD_STOP)                                   state_nx = S_IDLE;
          else if (bus.host_data == CMD_INST || bus.host_data == CMD_DATA) state_nx = S_ADDR_H;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q      <= 1'b0;
      tgt_data_q   <= 1'b0;
      addr_q       <= '0;
      cnt_q        <= '0;
      hi_q         <= '0;
      pause_q      <= 1'b0;
      err_q        <= 1'b0;
      inst_cen_q   <= 1'b1;
      inst_wen_q   <= 1'b1;
      inst_addr_q  <= '0;
      inst_wdata_q <= '0;
      data_cen_q   <= 1'b1;
      data_wen_q   <= 1'b1;
      data_addr_q  <= '0;
      data_wdata_q <= '0;
    end else begin
      ready_q    <= 1'b1;
      // Strobes last one cycle: they fall back to idle unless re-armed below.
      inst_cen_q <= 1'b1;
      inst_wen_q <= 1'b1;
      data_cen_q <= 1'b1;
      data_wen_q <= 1'b1;
      if (accept) begin
        case (state)
          S_IDLE: begin
            if (bus.host_data == CMD_INST || bus.host_data == CMD_DATA)
              tgt_data_q <= (bus.host_data == CMD_DATA);
            else if (bus.host_data != CMD_RUN && bus.host_data != CMD_PAUSE &&
                     bus.host_data != CMD_STOP)
              err_q <= 1'b1;
          end
          S_ADDR_H: addr_q[DATA_AW-1:8] <= bus.host_data[DATA_AW-9:0];
          S_ADDR_L: addr_q[7:0]         <= bus.host_data;
          S_CNT_H:  cnt_q[15:8]         <= bus.host_data;
          S_CNT_L:  cnt_q[7:0]          <= bus.host_data;
          S_DATA_H: hi_q                <= bus.host_data;
          S_DATA_L: begin
            if (tgt_data_q) begin
              data_cen_q   <= 1'b0;
              data_wen_q   <= 1'b0;
              data_addr_q  <= addr_q;
              data_wdata_q <= {hi_q, bus.host_data};
            end else begin
              inst_cen_q   <= 1'b0;
              inst_wen_q   <= 1'b0;
              inst_addr_q  <= addr_q[INST_AW-1:0];
              inst_wdata_q <= {hi_q, bus.host_data};
            end
            // Instruction addresses wrap at 2^INST_AW because only the low bits are used.
            addr_q <= addr_q + ADDR_ONE;
            cnt_q  <= cnt_q - 16'd1;
          end
          S_RUN: begin
            case (bus.host_data)
              CMD_PAUSE: pause_q <= !pause_q;
              CMD_STOP:  pause_q <= 1'b0;
              CMD_INST, CMD_DATA: begin
                pause_q    <= 1'b0;
                tgt_data_q <= (bus.host_data == CMD_DATA);
              end
              CMD_RUN: begin end
              default:   err_q <= 1'b1;
            endcase
          end
          default: begin end
        endcase
      end
    end
  end

  assign bus.host_ready     = ready_q;
  assign bus.instsram_ctrl  = run_mode ? bus.ctrl_instsram
                                       : {inst_wen_q, inst_cen_q, inst_addr_q};
  assign bus.datasram_ctrl  = run_mode ? bus.ctrl_datasram
                                       : {data_wen_q, data_cen_q, data_addr_q};
  assign bus.instsram_wdata = inst_wdata_q;
  assign bus.datasram_wdata = run_mode ? bus.core_wdata : data_wdata_q;
  assign bus.ctrl_rst       = !run_mode;
  assign bus.ctrl_pause     = pause_q;
  assign bus.load_err       = err_q;

endmodule

// File: tb/tb_bnn_loader.sv
// Directed bench for bnn_loader: load frames, address wrap, run/pause/stop, errors,
// and reset mid-frame, with a negedge monitor collecting SRAM write strobes.
module tb_bnn_loader;

  typedef struct {
    logic [12:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef logic [7:0] bytes_t[$];

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  wr_t  inst_q[$];
  wr_t  data_q[$];
  logic adjacent_seen = 1'b0;
  logic run_seen      = 1'b0;
  logic prev_strobe   = 1'b0;

  bnn_loader_if #(.INST_AW(11), .DATA_AW(13)) bus ();

  bnn_loader #(.INST_AW(11), .DATA_AW(13)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = !clk;

  // Records loader-mode write strobes and flags adjacent strobes or any RUN interval.
  always @(negedge clk) begin
    logic si, sd;
    si = !bus.instsram_ctrl[11] && !bus.instsram_ctrl[12];
    sd = !bus.datasram_ctrl[13] && !bus.datasram_ctrl[14];
    if (rst && bus.ctrl_rst) begin
      if (si) inst_q.push_back('{addr: {2'b00, bus.instsram_ctrl[10:0]}, data: bus.instsram_wdata});
      if (sd) data_q.push_back('{addr: bus.datasram_ctrl[12:0], data: bus.datasram_wdata});
      if ((si || sd) && prev_strobe) adjacent_seen = 1'b1;
      prev_strobe = si || sd;
    end else begin
      prev_strobe = 1'b0;
    end
    if (!bus.ctrl_rst) run_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bytes(input bytes_t bq);
    foreach (bq[i]) begin
      bus.host_valid = 1'b1;
      bus.host_data  = bq[i];
      @(posedge clk);
      #1;
    end
    bus.host_valid = 1'b0;
  endtask

  task automatic clear_mon();
    inst_q.delete();
    data_q.delete();
    adjacent_seen = 1'b0;
    run_seen      = 1'b0;
  endtask

  initial begin
    bus.host_valid    = 1'b0;
    bus.host_data     = 8'h00;
    bus.ctrl_instsram = 13'h0803;
    bus.ctrl_datasram = 15'h4123;
    bus.core_wdata    = 16'hBEEF;

    // Reset state
    tick(2);
    check("rst_ready",  32'(bus.host_ready),     32'h0);
    check("rst_crst",   32'(bus.ctrl_rst),       32'h1);
    check("rst_pause",  32'(bus.ctrl_pause),     32'h0);
    check("rst_err",    32'(bus.load_err),       32'h0);
    check("rst_ibus",   32'(bus.instsram_ctrl),  32'h1800);
    check("rst_dbus",   32'(bus.datasram_ctrl),  32'h6000);
    check("rst_iwd",    32'(bus.instsram_wdata), 32'h0);
    check("rst_dwd",    32'(bus.datasram_wdata), 32'h0);
    @(negedge clk) rst = 1'b1;
    tick(1);
    check("ready_up", 32'(bus.host_ready), 32'h1);

    // Instruction load of two words; second strobe visible right after the last byte
    clear_mon();
    send_bytes('{8'hA1, 8'h00, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD});
    check("t1_strobe_bus", 32'(bus.instsram_ctrl),  32'h0001);
    check("t1_strobe_wd",  32'(bus.instsram_wdata), 32'hABCD);
    tick(1);
    check("t1_idle_bus", 32'(bus.instsram_ctrl), 32'h1801);
    tick(2);
    check("t1_n_inst", 32'(inst_q.size()), 32'd2);
    check("t1_w0_addr", 32'(inst_q[0].addr), 32'h000);
    check("t1_w0_data", 32'(inst_q[0].data), 32'h1234);
    check("t1_w1_addr", 32'(inst_q[1].addr), 32'h001);
    check("t1_w1_data", 32'(inst_q[1].data), 32'hABCD);
    check("t1_n_data",  32'(data_q.size()), 32'd0);
    check("t1_no_run",  32'(run_seen), 32'h0);
    check("t1_no_adj",  32'(adjacent_seen), 32'h0);

    // Address wrap at 2^11
    clear_mon();
    send_bytes('{8'hA1, 8'h07, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h11, 8'h22, 8'h22});
    tick(2);
    check("t2_n_inst",  32'(inst_q.size()), 32'd2);
    check("t2_w0_addr", 32'(inst_q[0].addr), 32'h7FF);
    check("t2_w1_addr", 32'(inst_q[1].addr), 32'h000);
    check("t2_w1_data", 32'(inst_q[1].data), 32'h2222);

    // Data load then run, back-to-back
    clear_mon();
    send_bytes('{8'hA2, 8'h1F, 8'hFF, 8'h00, 8'h01, 8'h55, 8'hAA, 8'hA5});
    check("t3_crst",    32'(bus.ctrl_rst),       32'h0);
    check("t3_ipass",   32'(bus.instsram_ctrl),  32'h0803);
    check("t3_dpass",   32'(bus.datasram_ctrl),  32'h4123);
    check("t3_dwpass",  32'(bus.datasram_wdata), 32'hBEEF);
    bus.ctrl_instsram = 13'h0455;
    #1;
    check("t3_ipass2",  32'(bus.instsram_ctrl),  32'h0455);
    check("t3_n_data",  32'(data_q.size()), 32'd1);
    check("t3_w_addr",  32'(data_q[0].addr), 32'h1FFF);
    check("t3_w_data",  32'(data_q[0].data), 32'h55AA);
    check("t3_n_inst",  32'(inst_q.size()), 32'd0);

    // Pause toggling and stop
    send_bytes('{8'hA0});
    check("t4_pause1", 32'(bus.ctrl_pause), 32'h1);
    send_bytes('{8'hA5, 8'hA0});
    check("t4_pause0", 32'(bus.ctrl_pause), 32'h0);
    check("t4_still_run", 32'(bus.ctrl_rst), 32'h0);
    send_bytes('{8'hA0, 8'hA3});
    check("t4_stop_crst",  32'(bus.ctrl_rst),       32'h1);
    check("t4_stop_pause", 32'(bus.ctrl_pause),     32'h0);
    check("t4_stop_ibus",  32'(bus.instsram_ctrl),  32'h1800);
    check("t4_stop_dbus",  32'(bus.datasram_ctrl),  32'h7FFF);
    check("t4_stop_dwd",   32'(bus.datasram_wdata), 32'h55AA);
    send_bytes('{8'hA0});
    check("t4_idle_pause", 32'(bus.ctrl_pause), 32'h0);
    check("t4_idle_err",   32'(bus.load_err),   32'h0);
    check("t4_idle_crst",  32'(bus.ctrl_rst),   32'h1);

    // Implicit stop: a load command while running
    clear_mon();
    send_bytes('{8'hA5, 8'hA0, 8'hA1});
    check("t5_crst",  32'(bus.ctrl_rst),   32'h1);
    check("t5_pause", 32'(bus.ctrl_pause), 32'h0);
    clear_mon();
    send_bytes('{8'h00, 8'h20, 8'h00, 8'h01, 8'h77, 8'h88});
    tick(2);
    check("t5_n_inst", 32'(inst_q.size()), 32'd1);
    check("t5_w_addr", 32'(inst_q[0].addr), 32'h020);
    check("t5_w_data", 32'(inst_q[0].data), 32'h7788);

    // Unknown command, then an empty frame, then a frame that proves IDLE
    clear_mon();
    send_bytes('{8'h7E});
    check("t6_err", 32'(bus.load_err), 32'h1);
    check("t6_crst", 32'(bus.ctrl_rst), 32'h1);
    send_bytes('{8'hA1, 8'h00, 8'h00, 8'h00, 8'h00});
    tick(2);
    check("t6_n_inst", 32'(inst_q.size()), 32'd0);
    check("t6_n_data", 32'(data_q.size()), 32'd0);
    check("t6_err_sticky", 32'(bus.load_err), 32'h1);
    send_bytes('{8'hA2, 8'h00, 8'h05, 8'h00, 8'h01, 8'h0F, 8'hF0});
    tick(2);
    check("t6_n_data2", 32'(data_q.size()), 32'd1);
    check("t6_w_addr",  32'(data_q[0].addr), 32'h0005);
    check("t6_w_data",  32'(data_q[0].data), 32'h0FF0);

    // Reset mid-frame
    clear_mon();
    send_bytes('{8'hA1, 8'h00, 8'h10, 8'h00, 8'h01, 8'h12});
    @(negedge clk) rst = 1'b0;
    #1;
    check("t7_ready", 32'(bus.host_ready),    32'h0);
    check("t7_err",   32'(bus.load_err),      32'h0);
    check("t7_ibus",  32'(bus.instsram_ctrl), 32'h1800);
    check("t7_dbus",  32'(bus.datasram_ctrl), 32'h6000);
    check("t7_dwd",   32'(bus.datasram_wdata),32'h0);
    bus.host_valid = 1'b1;
    bus.host_data  = 8'h34;
    tick(2);
    bus.host_valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    tick(2);
    check("t7_n_inst", 32'(inst_q.size()), 32'd0);
    send_bytes('{8'hA1, 8'h00, 8'h10, 8'h00, 8'h01, 8'h12, 8'h34});
    tick(2);
    check("t7_n_inst2", 32'(inst_q.size()), 32'd1);
    check("t7_w_addr",  32'(inst_q[0].addr), 32'h010);
    check("t7_w_data",  32'(inst_q[0].data), 32'h1234);
    check("t7_no_adj",  32'(adjacent_seen), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
